// File: rtl/jstk2_pkg.sv
// Shared JSTK2 joystick definitions: FSM states, frame size, byte map.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package jstk2_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam int JSTK2_FRAME_BYTES = 5;

    localparam logic [2:0] IDX_XL  = 3'd0;
    localparam logic [2:0] IDX_XH  = 3'd1;
    localparam logic [2:0] IDX_YL  = 3'd2;
    localparam logic [2:0] IDX_YH  = 3'd3;
    localparam logic [2:0] IDX_BTN = 3'd4;

    // Position/button snapshot taken at the start of a frame.
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] btn;
    } pos_t;

    // Byte the joystick reports at position idx; bytes past the frame read 0.
    function automatic logic [7:0] tx_byte(input pos_t p, input logic [2:0] idx,
                                           input int frame_bytes);
        logic [7:0] b;
        b = 8'h00;
        if (int'(idx) < frame_bytes) begin
            case (idx)
                IDX_XL:  b = p.x[7:0];
                IDX_XH:  b = {6'b0, p.x[9:8]};
                IDX_YL:  b = p.y[7:0];
                IDX_YH:  b = {6'b0, p.y[9:8]};
                IDX_BTN: b = p.btn;
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer plus edge detector for a small bus of async inputs.
// Latency: lvl is STAGES clocks after the input; rise/fall strobes are combinational off lvl.
// Backpressure: none; strobes are single-cycle pulses.
// Ports: clk/rst_n; din async bus; lvl synced levels; rise/fall one-cycle edge strobes.
module spi_in_sync #(
    parameter int W      = 3,
    parameter int STAGES = 2   // must be at least 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] lvl,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] chain [STAGES];
    logic [W-1:0] prev;

    // Reset to all-zero: a chip select already low at reset release then never
    // shows a falling edge, so a frame in progress is ignored until CS_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= '0;
            prev <= '0;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
            prev <= chain[STAGES-1];
        end
    end

    assign lvl  = chain[STAGES-1];
    assign rise = lvl & ~prev;
    assign fall = ~lvl & prev;

endmodule

// File: rtl/jstk2_spi_responder.sv
// SPI mode-0 slave emulating the JSTK2 joystick: returns X/Y/buttons, captures MOSI bytes.
// Latency: o_MISO moves SYNC_STAGES+1 CLKs after the physical SCK fall; o_RX_DV likewise after the 8th rise.
// Backpressure: none; the master owns timing, outputs are one-CLK pulses.
// Ports: CLK/i_Rst_L; SPI pins i_SCK/i_CS_n/i_MOSI/o_MISO/o_MISO_OE; position inputs
//        i_x_pos/i_y_pos/i_buttons; RX byte strobe o_RX_DV/o_RX_Byte/o_RX_Index;
//        frame status o_Frame_Done/o_Frame_Err/o_Busy.
module jstk2_spi_responder
    import jstk2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BYTES = JSTK2_FRAME_BYTES
) (
    input  logic       CLK,
    input  logic       i_Rst_L,
    input  logic       i_SCK,
    input  logic       i_CS_n,
    input  logic       i_MOSI,
    output logic       o_MISO,
    output logic       o_MISO_OE,
    input  logic [9:0] i_x_pos,
    input  logic [9:0] i_y_pos,
    input  logic [7:0] i_buttons,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic [2:0] o_RX_Index,
    output logic       o_Frame_Done,
    output logic       o_Frame_Err,
    output logic       o_Busy
);

    localparam int B_SCK  = 2;
    localparam int B_CS   = 1;
    localparam int B_MOSI = 0;

    logic [2:0] s_lvl, s_rise, s_fall;

    spi_in_sync #(.W(3), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (CLK),
        .rst_n (i_Rst_L),
        .din   ({i_SCK, i_CS_n, i_MOSI}),
        .lvl   (s_lvl),
        .rise  (s_rise),
        .fall  (s_fall)
    );

    logic sck_rise, sck_fall, cs_rise, cs_fall, mosi;
    assign sck_rise = s_rise[B_SCK];
    assign sck_fall = s_fall[B_SCK];
    assign cs_rise  = s_rise[B_CS];
    assign cs_fall  = s_fall[B_CS];
    assign mosi     = s_lvl[B_MOSI];

    logic unused_sync;
    assign unused_sync = ^{s_lvl[B_SCK], s_lvl[B_CS], s_rise[B_MOSI], s_fall[B_MOSI]};

    state_t     state, next_state;
    logic       start, finish, cs_pend;
    pos_t       snap, cur_pos;
    logic [7:0] tx_sr, rx_sr;
    logic [2:0] tx_bits, rx_bits, tx_idx, rx_cnt;
    logic [2:0] tx_idx_nxt;
    logic [7:0] first_byte, next_byte;
    logic       shift_ok;

    assign cur_pos    = '{x: i_x_pos, y: i_y_pos, btn: i_buttons};
    assign first_byte = tx_byte(cur_pos, IDX_XL, FRAME_BYTES);
    // Byte index saturates at 7; every index from FRAME_BYTES up reads 0 anyway.
    assign tx_idx_nxt = (tx_idx == 3'd7) ? 3'd7 : tx_idx + 3'd1;
    assign next_byte  = tx_byte(snap, tx_idx_nxt, FRAME_BYTES);
    // CS_n rising wins over a coincident SCK edge, which is dropped.
    assign shift_ok   = (state == S_ACTIVE) && !cs_rise;

    always_ff @(posedge CLK or negedge i_Rst_L) begin
        if (!i_Rst_L) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (cs_fall || cs_pend) begin
                    start      = 1'b1;
                    next_state = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (cs_rise) begin
                    finish     = 1'b1;
                    next_state = S_DONE;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_MISO       <= 1'b0;
            o_MISO_OE    <= 1'b0;
            o_RX_DV      <= 1'b0;
            o_RX_Byte    <= 8'h00;
            o_RX_Index   <= 3'd0;
            o_Frame_Done <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Busy       <= 1'b0;
            cs_pend      <= 1'b0;
            snap         <= '0;
            tx_sr        <= 8'h00;
            rx_sr        <= 8'h00;
            tx_bits      <= 3'd0;
            rx_bits      <= 3'd0;
            tx_idx       <= 3'd0;
            rx_cnt       <= 3'd0;
        end else begin
            o_RX_DV      <= 1'b0;
            o_Frame_Done <= 1'b0;

            // A new select seen during the DONE cycle is held for the next IDLE.
            if (state == S_DONE && cs_fall) cs_pend <= 1'b1;
            else if (start)                 cs_pend <= 1'b0;

            if (start) begin
                snap      <= cur_pos;
                tx_sr     <= first_byte;
                o_MISO    <= first_byte[7];
                tx_bits   <= 3'd0;
                rx_bits   <= 3'd0;
                tx_idx    <= 3'd0;
                rx_cnt    <= 3'd0;
                o_MISO_OE <= 1'b1;
                o_Busy    <= 1'b1;
            end

            if (shift_ok && sck_rise) begin
                rx_sr   <= {rx_sr[6:0], mosi};
                rx_bits <= rx_bits + 3'd1;
                if (rx_bits == 3'd7) begin
                    o_RX_DV    <= 1'b1;
                    o_RX_Byte  <= {rx_sr[6:0], mosi};
                    o_RX_Index <= rx_cnt;
                    rx_cnt     <= (rx_cnt == 3'd7) ? 3'd7 : rx_cnt + 3'd1;
                end
            end

            if (shift_ok && sck_fall) begin
                tx_bits <= tx_bits + 3'd1;
                if (tx_bits == 3'd7) begin
                    tx_sr  <= next_byte;
                    o_MISO <= next_byte[7];
                    tx_idx <= tx_idx_nxt;
                end else begin
                    tx_sr  <= {tx_sr[6:0], 1'b0};
                    o_MISO <= tx_sr[6];
                end
            end

            if (finish) begin
                o_Frame_Done <= 1'b1;
                // rx_cnt stays 0 until a full byte lands, so it doubles as "no bytes".
                o_Frame_Err  <= (rx_bits != 3'd0) || (rx_cnt == 3'd0);
                o_MISO_OE    <= 1'b0;
                o_MISO       <= 1'b0;
            end

            if (state == S_DONE) o_Busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jstk2_spi_responder.sv
// Bench for jstk2_spi_responder: mode-0 master model against a byte-level reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_jstk2_spi_responder;

    localparam int HALF = 12;

    logic       CLK = 1'b0;
    logic       rst_l, sck, cs_n, mosi;
    logic       miso, miso_oe, rx_dv, frame_done, frame_err, busy;
    logic [9:0] x_pos, y_pos;
    logic [7:0] buttons, rx_byte;
    logic [2:0] rx_index;

    always #20 CLK = ~CLK;

    jstk2_spi_responder #(.SYNC_STAGES(2), .FRAME_BYTES(5)) dut (
        .CLK          (CLK),
        .i_Rst_L      (rst_l),
        .i_SCK        (sck),
        .i_CS_n       (cs_n),
        .i_MOSI       (mosi),
        .o_MISO       (miso),
        .o_MISO_OE    (miso_oe),
        .i_x_pos      (x_pos),
        .i_y_pos      (y_pos),
        .i_buttons    (buttons),
        .o_RX_DV      (rx_dv),
        .o_RX_Byte    (rx_byte),
        .o_RX_Index   (rx_index),
        .o_Frame_Done (frame_done),
        .o_Frame_Err  (frame_err),
        .o_Busy       (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Observed RX bytes and frame completions.
    logic [7:0] rx_q[$];
    logic [2:0] idx_q[$];
    int         done_cnt = 0;
    logic       last_err = 1'b0;

    always @(negedge CLK) begin
        if (rx_dv) begin
            rx_q.push_back(rx_byte);
            idx_q.push_back(rx_index);
        end
        if (frame_done) begin
            done_cnt++;
            last_err = frame_err;
        end
    end

    logic [7:0] mo_data [16];
    logic [7:0] mi_data [16];
    int         rst_bit = -1;
    int         chg_bit = -1;
    logic [9:0] chg_x;
    logic [9:0] ex_x, ex_y;
    logic [7:0] ex_b;
    int         done_base;

    // Reference: what the joystick should report at byte k of a frame.
    function automatic logic [7:0] exp_tx(input int k);
        case (k)
            0:       return ex_x[7:0];
            1:       return {6'b0, ex_x[9:8]};
            2:       return ex_y[7:0];
            3:       return {6'b0, ex_y[9:8]};
            4:       return ex_b;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic exp_err(input int nbits);
        return (nbits % 8 != 0) || (nbits < 8);
    endfunction

    task automatic spi_frame(input int nbits);
        cs_n = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            mosi = mo_data[b/8][7 - b%8];
            repeat (HALF) @(negedge CLK);
            sck = 1'b1;
            mi_data[b/8][7 - b%8] = miso;
            if (b == chg_bit) x_pos = chg_x;
            if (b == rst_bit) begin
                rst_l = 1'b0;
                #1;
                chk("rst_mid_outs", {miso, miso_oe, rx_dv, rx_byte, rx_index,
                                     frame_done, frame_err, busy}, 32'd0);
                done_base = done_cnt;
                rx_q.delete();
                idx_q.delete();
                repeat (3) @(negedge CLK);
                rst_l = 1'b1;
            end
            repeat (HALF) @(negedge CLK);
            sck = 1'b0;
            if (rst_bit >= 0 && b == nbits - 1) chk("rst_oe_low", miso_oe, 1'b0);
        end
        repeat (HALF) @(negedge CLK);
        cs_n = 1'b1;
    endtask

    task automatic begin_frame();
        ex_x = x_pos;
        ex_y = y_pos;
        ex_b = buttons;
        rx_q.delete();
        idx_q.delete();
        done_base = done_cnt;
    endtask

    task automatic check_data(input int nbits, input string tag);
        int nb;
        nb = nbits / 8;
        for (int k = 0; k < nb; k++)
            chk($sformatf("%s_miso%0d", tag, k), mi_data[k], exp_tx(k));
        chk($sformatf("%s_dv_count", tag), rx_q.size(), nb);
        for (int k = 0; k < nb && k < rx_q.size(); k++) begin
            chk($sformatf("%s_rx%0d", tag, k), rx_q[k], mo_data[k]);
            chk($sformatf("%s_idx%0d", tag, k), idx_q[k], (k > 7) ? 7 : k);
        end
    endtask

    task automatic check_end(input string tag, input int ndone, input logic err);
        chk($sformatf("%s_done", tag), done_cnt - done_base, ndone);
        chk($sformatf("%s_err", tag), last_err, err);
        chk($sformatf("%s_oe", tag), miso_oe, 1'b0);
        chk($sformatf("%s_busy", tag), busy, 1'b0);
    endtask

    task automatic run_frame(input int nbits, input string tag);
        begin_frame();
        spi_frame(nbits);
        repeat (8) @(negedge CLK);
        check_data(nbits, tag);
        check_end(tag, 1, exp_err(nbits));
    endtask

    task automatic rand_mosi();
        for (int k = 0; k < 16; k++) mo_data[k] = 8'($urandom);
    endtask

    initial begin
        int d0, nbits;
        rst_l = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        x_pos = '0; y_pos = '0; buttons = '0;
        repeat (3) @(negedge CLK);
        chk("reset_outs", {miso, miso_oe, rx_dv, rx_byte, rx_index,
                           frame_done, frame_err, busy}, 32'd0);
        rst_l = 1'b1;
        repeat (5) @(negedge CLK);
        chk("idle_busy", busy, 1'b0);

        // Directed full frame.
        x_pos = 10'h2A5; y_pos = 10'h013; buttons = 8'h03;
        mo_data[0] = 8'h84; mo_data[1] = 8'h01; mo_data[2] = 8'h02;
        mo_data[3] = 8'h03; mo_data[4] = 8'h00;
        run_frame(40, "full");

        // Snapshot: X changes after byte 0, frame must not see it.
        x_pos = 10'h100; y_pos = 10'h055; buttons = 8'hA0;
        chg_bit = 8; chg_x = 10'h3FF;
        rand_mosi();
        run_frame(40, "snap1");
        chg_bit = -1;
        run_frame(40, "snap2");
        chk("snap2_xl", mi_data[0], 8'hFF);

        // Short frame: 12 SCK cycles.
        rand_mosi();
        run_frame(12, "short");

        // Long frame: 9 bytes.
        rand_mosi();
        run_frame(72, "long");

        // Reset at bit 19, released with CS_n still low.
        rand_mosi();
        rst_bit = 19;
        begin_frame();
        spi_frame(40);
        repeat (8) @(negedge CLK);
        chk("rst_no_done", done_cnt - done_base, 0);
        chk("rst_no_dv", rx_q.size(), 0);
        chk("rst_oe_after", miso_oe, 1'b0);
        rst_bit = -1;
        rand_mosi();
        run_frame(40, "post_rst");

        // Back-to-back frames with a 2-CLK CS_n-high gap.
        rand_mosi();
        x_pos = 10'h1C7; y_pos = 10'h2E1; buttons = 8'h5A;
        begin_frame();
        d0 = done_base;
        spi_frame(40);
        check_data(40, "b2b1");
        x_pos = 10'($urandom); y_pos = 10'($urandom); buttons = 8'($urandom);
        rand_mosi();
        begin_frame();
        repeat (2) @(negedge CLK);
        spi_frame(40);
        repeat (8) @(negedge CLK);
        check_data(40, "b2b2");
        done_base = d0;
        check_end("b2b", 2, 1'b0);

        // Randomized frames.
        for (int r = 0; r < 6; r++) begin
            x_pos = 10'($urandom); y_pos = 10'($urandom); buttons = 8'($urandom);
            rand_mosi();
            nbits = $urandom_range(1, 9) * 8;
            if ($urandom_range(0, 3) == 0) nbits += $urandom_range(1, 7);
            if (r == 5) nbits = $urandom_range(1, 7);
            run_frame(nbits, $sformatf("rnd%0d", r));
            repeat ($urandom_range(3, 20)) @(negedge CLK);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
